// File: rtl/voice_udp_packer_pkg.sv
// voice_pkt_pkg: definitions shared by the voice UDP payload packer.
//   pkt_state_t    - serializer FSM states. Each non-IDLE state names the byte
//                    that is currently presented on tx_data.
//   PKT_HDR_BYTES  - bytes of frame header (16-bit sequence number).
//   BYTES_PER_PAIR - bytes per stereo pair (L lo/hi, R lo/hi).
//   payload_len()  - total frame length in bytes for a given pair count.
package voice_pkt_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SEQ_H = 3'd1,
    SEQ_L = 3'd2,
    L_LO  = 3'd3,
    L_HI  = 3'd4,
    R_LO  = 3'd5,
    R_HI  = 3'd6
  } pkt_state_t;

  localparam int PKT_HDR_BYTES  = 2;
  localparam int BYTES_PER_PAIR = 4;

  function automatic int payload_len(input int samples_per_pkt);
    return PKT_HDR_BYTES + BYTES_PER_PAIR * samples_per_pkt;
  endfunction

endpackage

// File: rtl/voice_udp_packer_if.sv
// voice_tx_if: byte stream from the packer to the UDP transmit path.
//   tx_data  - payload byte
//   tx_valid - tx_data/tx_sof/tx_eof are meaningful
//   tx_ready - sink can take the byte
//   tx_sof   - byte is the first of a frame (sequence high byte)
//   tx_eof   - byte is the last of a frame (last R high byte)
// Handshake: a byte transfers on a rising clock edge where tx_valid and
// tx_ready are both 1. Once tx_valid is raised, the master holds tx_data,
// tx_sof and tx_eof unchanged and keeps tx_valid high until that transfer;
// tx_valid never depends on tx_ready. The slave may change tx_ready freely.
interface voice_tx_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       tx_sof;
  logic       tx_eof;

  modport master (output tx_data, output tx_valid, output tx_sof, output tx_eof,
                  input  tx_ready);
  modport slave  (input  tx_data, input  tx_valid, input  tx_sof, input  tx_eof,
                  output tx_ready);
endinterface

// File: rtl/voice_udp_packer_fifo.sv
// voice_sample_fifo: single-clock synchronous FIFO of stereo pairs.
//   clk, rst_n  - clock, async active-low reset (pointers/count only)
//   wr_en, din  - push; ignored while full
//   rd_en       - pop; ignored while empty
//   dout        - head word, first-word fall-through
//   dout_next   - word behind the head; valid while count >= 2
//   count       - occupancy 0..DEPTH
//   full, empty - derived from the registered count, so they reflect the
//                 result of the previous cycle's push/pop combination
module voice_sample_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 512
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       wr_en,
  input  logic [WIDTH-1:0]           din,
  input  logic                       rd_en,
  output logic [WIDTH-1:0]           dout,
  output logic [WIDTH-1:0]           dout_next,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_wr;
  logic             do_rd;

  assign full      = (count == CW'(DEPTH));
  assign empty     = (count == '0);
  assign do_wr     = wr_en && !full;
  assign do_rd     = rd_en && !empty;
  assign dout      = mem[rd_ptr];
  // Lets the serializer load the next pair's first byte on the same edge
  // that pops the current pair.
  assign dout_next = mem[rd_ptr + AW'(1)];

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + AW'(1);
      if (do_rd) rd_ptr <= rd_ptr + AW'(1);
      case ({do_wr, do_rd})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/voice_udp_packer.sv
// voice_udp_packer: packs stereo 16-bit PCM pairs into fixed-length UDP
// payload frames: 16-bit sequence number (big-endian) followed by
// SAMPLES_PER_PKT pairs, each sent L[7:0], L[15:8], R[7:0], R[15:8].
//   sck          - sole clock (I2S bit clock)
//   rst_n        - async active-low reset
//   ldata, l_vld - left sample and its 1-cycle strobe
//   rdata, r_vld - right sample and its strobe; completes a pair
//   enable       - 1 = capture and start frames; 0 = finish frame, then idle
//   tx           - byte stream master (voice_tx_if)
//   seq_num      - sequence number of the frame in progress / next frame
//   overflow_cnt - pairs dropped on FIFO full, saturating
//   fsm_state    - current serializer state, for observation
module voice_udp_packer
  import voice_pkt_pkg::*;
#(
  parameter int DATA_WIDTH      = 16,
  parameter int SAMPLES_PER_PKT = 256,
  parameter int FIFO_DEPTH      = 512
) (
  input  logic                  sck,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] ldata,
  input  logic [DATA_WIDTH-1:0] rdata,
  input  logic                  l_vld,
  input  logic                  r_vld,
  input  logic                  enable,
  voice_tx_if.master            tx,
  output logic [15:0]           seq_num,
  output logic [15:0]           overflow_cnt,
  output pkt_state_t            fsm_state
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int PW = (SAMPLES_PER_PKT > 1) ? $clog2(SAMPLES_PER_PKT) : 1;
  localparam int FW = 2 * DATA_WIDTH;

  // Capture
  logic [DATA_WIDTH-1:0] l_hold;
  logic                  l_seen;
  logic                  push_req;
  logic [FW-1:0]         push_pair;

  // FIFO
  logic          fifo_wr;
  logic          fifo_rd;
  logic [FW-1:0] fifo_dout;
  logic [FW-1:0] fifo_dout_next;
  logic [CW-1:0] fifo_count;
  logic          fifo_full;
  logic          fifo_empty;

  // Serializer
  pkt_state_t    state;
  logic [7:0]    data_q;
  logic          valid_q;
  logic          sof_q;
  logic          eof_q;
  logic [PW-1:0] pair_cnt;
  logic [15:0]   seq_q;
  logic          hs;
  logic          last_pair;

  // A simultaneous l_vld/r_vld bypasses the holding register.
  assign push_req  = enable && r_vld && (l_vld || l_seen);
  assign push_pair = l_vld ? {ldata, rdata} : {l_hold, rdata};
  assign fifo_wr   = push_req && !fifo_full;

  always_ff @(posedge sck or negedge rst_n) begin
    if (!rst_n) begin
      l_hold <= '0;
      l_seen <= 1'b0;
    end else if (l_vld && r_vld) begin
      l_seen <= 1'b0;
    end else if (l_vld) begin
      l_hold <= ldata;
      l_seen <= 1'b1;
    end else if (r_vld) begin
      l_seen <= 1'b0;
    end
  end

  always_ff @(posedge sck or negedge rst_n) begin
    if (!rst_n) begin
      overflow_cnt <= '0;
    end else if (push_req && fifo_full && overflow_cnt != 16'hFFFF) begin
      overflow_cnt <= overflow_cnt + 16'd1;
    end
  end

  voice_sample_fifo #(
    .WIDTH (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (sck),
    .rst_n     (rst_n),
    .wr_en     (fifo_wr),
    .din       (push_pair),
    .rd_en     (fifo_rd),
    .dout      (fifo_dout),
    .dout_next (fifo_dout_next),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign hs        = valid_q && tx.tx_ready;
  assign last_pair = (pair_cnt == PW'(SAMPLES_PER_PKT - 1));
  assign fifo_rd   = hs && (state == R_HI) && !fifo_empty;

  // Pair layout in the FIFO word: {L[15:8], L[7:0], R[15:8], R[7:0]}.
  // A frame starts only with a whole frame buffered, so dout/dout_next are
  // always populated while it is being sent.
  always_ff @(posedge sck or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      data_q   <= '0;
      valid_q  <= 1'b0;
      sof_q    <= 1'b0;
      eof_q    <= 1'b0;
      pair_cnt <= '0;
      seq_q    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (enable && fifo_count >= CW'(SAMPLES_PER_PKT)) begin
            state   <= SEQ_H;
            valid_q <= 1'b1;
            data_q  <= seq_q[15:8];
            sof_q   <= 1'b1;
            eof_q   <= 1'b0;
          end
        end
        SEQ_H: if (hs) begin
          state  <= SEQ_L;
          data_q <= seq_q[7:0];
          sof_q  <= 1'b0;
        end
        SEQ_L: if (hs) begin
          state  <= L_LO;
          data_q <= fifo_dout[23:16];
        end
        L_LO: if (hs) begin
          state  <= L_HI;
          data_q <= fifo_dout[31:24];
        end
        L_HI: if (hs) begin
          state  <= R_LO;
          data_q <= fifo_dout[7:0];
        end
        R_LO: if (hs) begin
          state  <= R_HI;
          data_q <= fifo_dout[15:8];
          eof_q  <= last_pair;
        end
        R_HI: if (hs) begin
          if (last_pair) begin
            state    <= IDLE;
            valid_q  <= 1'b0;
            eof_q    <= 1'b0;
            pair_cnt <= '0;
            seq_q    <= seq_q + 16'd1;
          end else begin
            state    <= L_LO;
            pair_cnt <= pair_cnt + PW'(1);
            data_q   <= fifo_dout_next[23:16];
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign tx.tx_data  = data_q;
  assign tx.tx_valid = valid_q;
  assign tx.tx_sof   = sof_q;
  assign tx.tx_eof   = eof_q;
  assign seq_num     = seq_q;
  assign fsm_state   = state;

endmodule

// File: tb/tb_voice_udp_packer.sv
module tb_voice_udp_packer;
  import voice_pkt_pkg::*;

  localparam int SPP   = 4;
  localparam int DEPTH = 8;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] ldata, rdata;
  logic        l_vld, r_vld, enable;
  logic [15:0] seq_num, overflow_cnt;
  pkt_state_t  fsm_state;

  always #5 clk = ~clk;

  voice_tx_if tx_if ();

  voice_udp_packer #(
    .DATA_WIDTH      (16),
    .SAMPLES_PER_PKT (SPP),
    .FIFO_DEPTH      (DEPTH)
  ) dut (
    .sck          (clk),
    .rst_n        (rst_n),
    .ldata        (ldata),
    .rdata        (rdata),
    .l_vld        (l_vld),
    .r_vld        (r_vld),
    .enable       (enable),
    .tx           (tx_if.master),
    .seq_num      (seq_num),
    .overflow_cnt (overflow_cnt),
    .fsm_state    (fsm_state)
  );

  // ---------------- scoreboard / reference model ----------------
  int vectors     = 0;
  int miscompares = 0;

  logic [31:0] model_q[$];   // buffered pairs {L,R}, oldest first
  logic [9:0]  exp_q[$];     // expected {sof, eof, byte} of the current frame
  logic [15:0] seq_exp = 16'd0;
  logic [15:0] ovf_exp = 16'd0;
  int          bytes_in_frame = 0;
  int          frames_done = 0;
  logic [31:0] pr;
  logic [15:0] lw, rw;
  logic        last_b;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_push(input logic [15:0] l, input logic [15:0] r);
    if (model_q.size() < DEPTH) model_q.push_back({l, r});
    else if (ovf_exp != 16'hFFFF) ovf_exp++;
  endtask

  // Monitor: sampled on the falling edge, i.e. the state that the next
  // rising edge acts on.
  always @(negedge clk) begin
    if (rst_n && tx_if.tx_valid) begin
      if (exp_q.size() == 0) begin
        check("frame_start_pairs_buffered", 32'(model_q.size() >= SPP), 32'd1);
        check("seq_num_at_sof", seq_num, seq_exp);
        exp_q.push_back({1'b1, 1'b0, seq_exp[15:8]});
        exp_q.push_back({1'b0, 1'b0, seq_exp[7:0]});
        for (int p = 0; p < SPP && p < model_q.size(); p++) begin
          pr     = model_q[p];
          lw     = pr[31:16];
          rw     = pr[15:0];
          last_b = (p == SPP - 1);
          exp_q.push_back({2'b00, lw[7:0]});
          exp_q.push_back({2'b00, lw[15:8]});
          exp_q.push_back({2'b00, rw[7:0]});
          exp_q.push_back({1'b0, last_b, rw[15:8]});
        end
      end
      if (exp_q.size() != 0) begin
        // Also compared while stalled, which pins the held byte.
        check("tx_byte_sof_eof", {tx_if.tx_sof, tx_if.tx_eof, tx_if.tx_data}, exp_q[0]);
        if (tx_if.tx_ready) begin
          bytes_in_frame++;
          if (exp_q[0][8]) begin
            check("frame_len", bytes_in_frame, payload_len(SPP));
            frames_done++;
            seq_exp++;
            bytes_in_frame = 0;
            for (int p = 0; p < SPP && model_q.size() > 0; p++) void'(model_q.pop_front());
          end
          void'(exp_q.pop_front());
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_l(input logic [15:0] l);
    ldata = l; l_vld = 1'b1;
    tick();
    l_vld = 1'b0;
  endtask

  task automatic drive_r(input logic [15:0] r, input bit completes);
    rdata = r; r_vld = 1'b1;
    if (completes && enable) model_push(ldata, r);
    tick();
    r_vld = 1'b0;
  endtask

  task automatic push_pair(input logic [15:0] l, input logic [15:0] r);
    drive_l(l);
    drive_r(r, 1'b1);
  endtask

  task automatic push_random(input int n);
    for (int i = 0; i < n; i++) push_pair(16'($urandom), 16'($urandom));
  endtask

  task automatic wait_frames(input int target, input int budget, input bit rnd_ready);
    int n = 0;
    while (frames_done < target && n < budget) begin
      tick();
      if (rnd_ready) tx_if.tx_ready = 1'($urandom_range(0, 1));
      n++;
    end
    tx_if.tx_ready = 1'b1;
    check("frames_done", frames_done, target);
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    model_q.delete();
    exp_q.delete();
    seq_exp = 16'd0;
    ovf_exp = 16'd0;
    bytes_in_frame = 0;
  endtask

  // ---------------- directed sequence ----------------
  int f0;
  int n;

  initial begin
    ldata = '0; rdata = '0; l_vld = 1'b0; r_vld = 1'b0; enable = 1'b1;
    tx_if.tx_ready = 1'b1;
    apply_reset();
    repeat (3) tick();
    check("rst_tx_valid", tx_if.tx_valid, 1'b0);
    check("rst_tx_sof", tx_if.tx_sof, 1'b0);
    check("rst_tx_eof", tx_if.tx_eof, 1'b0);
    check("rst_tx_data", tx_if.tx_data, 8'h00);
    check("rst_seq_num", seq_num, 16'h0000);
    check("rst_overflow", overflow_cnt, 16'h0000);
    check("rst_state", fsm_state, IDLE);
    rst_n = 1'b1;
    tick();

    // 1: fixed pairs, sink always ready
    push_pair(16'h1111, 16'h2222);
    push_pair(16'h2222, 16'h3333);
    push_pair(16'h3333, 16'h4444);
    push_pair(16'h4444, 16'h5555);
    wait_frames(1, 200, 1'b0);
    check("t1_seq_num", seq_num, 16'd1);

    // 2: random data, random sink stalls, three frames
    for (int f = 0; f < 3; f++) begin
      push_random(SPP);
      wait_frames(frames_done + 1, 400, 1'b1);
    end
    check("t2_seq_num", seq_num, 16'd4);

    // 4: orphan r_vld ignored; second l_vld overwrites held left
    drive_r(16'hDEAD, 1'b0);
    tick();
    drive_l(16'hAAAA);
    drive_l(16'hBBBB);
    drive_r(16'hCCCC, 1'b1);
    push_random(SPP - 1);
    wait_frames(frames_done + 1, 200, 1'b0);
    check("t4_overflow", overflow_cnt, ovf_exp);

    // 5: enable drops at byte 6; frame completes, FIFO keeps the rest
    tx_if.tx_ready = 1'b0;
    push_random(DEPTH);
    f0 = frames_done;
    tick();
    tx_if.tx_ready = 1'b1;
    n = 0;
    while (bytes_in_frame < 6 && n < 100) begin tick(); n++; end
    check("t5_reached_byte6", 32'(bytes_in_frame >= 6), 32'd1);
    enable = 1'b0;
    wait_frames(f0 + 1, 200, 1'b0);
    repeat (40) tick();
    check("t5_no_new_frame", frames_done, f0 + 1);
    check("t5_idle_valid", tx_if.tx_valid, 1'b0);
    check("t5_idle_state", fsm_state, IDLE);
    check("t5_retained_pairs", model_q.size(), DEPTH - SPP);
    enable = 1'b1;
    wait_frames(f0 + 2, 200, 1'b0);

    // 3: sink blocked, DEPTH+5 pushes -> 5 drops, oldest pairs sent first
    tx_if.tx_ready = 1'b0;
    f0 = frames_done;
    push_random(DEPTH + 5);
    check("t3_overflow", overflow_cnt, 16'd5);
    check("t3_overflow_model", overflow_cnt, ovf_exp);
    tick();
    tx_if.tx_ready = 1'b1;
    wait_frames(f0 + 2, 400, 1'b0);
    check("t3_overflow_after", overflow_cnt, 16'd5);

    // 6: reset mid-frame
    tx_if.tx_ready = 1'b0;
    push_random(SPP);
    repeat (3) tick();
    check("t6_valid_before_reset", tx_if.tx_valid, 1'b1);
    #2;
    apply_reset();
    #1;
    check("t6_valid_async_drop", tx_if.tx_valid, 1'b0);
    check("t6_seq_num", seq_num, 16'h0000);
    check("t6_overflow", overflow_cnt, 16'h0000);
    tick();
    tick();
    rst_n = 1'b1;
    tx_if.tx_ready = 1'b1;
    f0 = frames_done;
    push_random(SPP);
    wait_frames(f0 + 1, 200, 1'b0);
    check("t6_seq_after", seq_num, 16'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
